line_clipper: RTL and testbench

LINE_CLIPPER -- requirements
Module: line_clipper

---
 rtl/defines_package.sv | 36 +++
 rtl/clip_div.sv | 84 ++++++++
 rtl/line_clipper.sv | 123 ++++++++++++
 tb/tb_line_clipper.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/defines_package.sv
// Shared types and constants for the Cohen-Sutherland line clipper.
package defines_package;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
    } Point2D;

    localparam logic signed [15:0] X_MIN = 16'sd0;
    localparam logic signed [15:0] X_MAX = 16'sd640;
    localparam logic signed [15:0] Y_MIN = 16'sd0;
    localparam logic signed [15:0] Y_MAX = 16'sd480;

    localparam logic [3:0] OC_LEFT   = 4'b0001;
    localparam logic [3:0] OC_RIGHT  = 4'b0010;
    localparam logic [3:0] OC_BOTTOM = 4'b0100;
    localparam logic [3:0] OC_TOP    = 4'b1000;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DIV,
        DONE
    } state_t;

    function automatic logic [3:0] outcode(input Point2D p);
        logic [3:0] c;
        c = '0;
        if (p.x < X_MIN) c = c | OC_LEFT;
        if (p.x > X_MAX) c = c | OC_RIGHT;
        if (p.y < Y_MIN) c = c | OC_BOTTOM;
        if (p.y > Y_MAX) c = c | OC_TOP;
        return c;
    endfunction

endpackage

// File: rtl/clip_div.sv
// Serial signed divider: restoring division on magnitudes, sign fixed up at the output.
module clip_div (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [33:0] num,
    input  logic signed [16:0] den,
    output logic               done,
    output logic [15:0]        quo
);

    logic        busy;
    logic [5:0]  cnt;
    logic [16:0] rem;
    logic [33:0] acc;
    logic [16:0] den_r;
    logic        neg;
    logic        zero;
    logic [33:0] num_mag;
    logic [16:0] den_mag;
    logic [50:0] s1, s2, s3;
    logic [15:0] q_mag;

    // One restoring step: returns {remainder[16:0], shifted quotient/numerator[33:0]}.
    function automatic logic [50:0] div_step(input logic [16:0] r, input logic [33:0] a,
                                             input logic [16:0] d);
        logic [17:0] sh;
        logic [16:0] trial;
        sh    = {r, a[33]};
        trial = sh[16:0] - d;
        if (sh >= {1'b0, d}) return {trial, a[32:0], 1'b1};
        else                 return {sh[16:0], a[32:0], 1'b0};
    endfunction

    always_comb begin
        if (num[33]) num_mag = -num;
        else         num_mag = num;
        if (den[16]) den_mag = -den;
        else         den_mag = den;
        s1 = div_step('0, num_mag, den_mag);
        s2 = div_step(s1[50:34], s1[33:0], den_mag);
        s3 = div_step(s2[50:34], s2[33:0], den_mag);
    end

    // The first three numerator bits are resolved at load so 34 bits finish in 32 cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            rem   <= '0;
            acc   <= '0;
            den_r <= '0;
            neg   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem   <= s3[50:34];
                acc   <= s3[33:0];
                den_r <= den_mag;
                neg   <= num[33] ^ den[16];
                zero  <= (den == '0);
                cnt   <= 6'd3;
                busy  <= 1'b1;
            end else if (busy) begin
                {rem, acc} <= div_step(rem, acc, den_r);
                cnt        <= cnt + 6'd1;
                if (cnt == 6'd33) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        q_mag = acc[15:0];
        if (zero)     quo = '0;
        else if (neg) quo = -q_mag;
        else          quo = q_mag;
    end

endmodule

// File: rtl/line_clipper.sv
// Cohen-Sutherland segment clipper against the inclusive window [0,640] x [0,480].
module line_clipper
    import defines_package::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    output logic   in_ready,
    input  Point2D p0,
    input  Point2D p1,
    output logic   out_valid,
    input  logic   out_ready,
    output logic   out_accept,
    output Point2D q0,
    output Point2D q1
);

    state_t             state, state_next;
    Point2D             w0, w1;
    logic [2:0]         iter;
    logic               accept;

    logic [3:0]         c0, c1, cs;
    logic               sel0;
    Point2D             pc, po, new_pt;
    logic signed [16:0] dx, dy, bound, xs, ys;
    logic signed [33:0] num;
    logic signed [16:0] den;
    logic               div_start, div_done;
    logic [15:0]        quo;

    clip_div u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .num   (num),
        .den   (den),
        .done  (div_done),
        .quo   (quo)
    );

    // Working registers are frozen during DIV, so the clip setup stays valid until done.
    always_comb begin
        c0   = outcode(w0);
        c1   = outcode(w1);
        sel0 = (c0 != 4'b0000);
        cs   = sel0 ? c0 : c1;
        pc   = sel0 ? w0 : w1;
        po   = sel0 ? w1 : w0;
        xs   = {pc.x[15], pc.x};
        ys   = {pc.y[15], pc.y};
        dx   = {po.x[15], po.x} - xs;
        dy   = {po.y[15], po.y} - ys;
        if ((cs & (OC_TOP | OC_BOTTOM)) != 4'b0000) begin
            bound    = ((cs & OC_TOP) != 4'b0000) ? 17'(Y_MAX) : 17'(Y_MIN);
            num      = dx * (bound - ys);
            den      = dy;
            new_pt.x = pc.x + quo;
            new_pt.y = bound[15:0];
        end else begin
            bound    = ((cs & OC_RIGHT) != 4'b0000) ? 17'(X_MAX) : 17'(X_MIN);
            num      = dy * (bound - xs);
            den      = dx;
            new_pt.x = bound[15:0];
            new_pt.y = pc.y + quo;
        end
    end

    always_comb begin
        state_next = state;
        div_start  = 1'b0;
        unique case (state)
            IDLE:  if (in_valid) state_next = CHECK;
            CHECK: begin
                if ((c0 | c1) == 4'b0000)
                    state_next = DONE;
                else if (((c0 & c1) != 4'b0000) || (iter == 3'd4))
                    state_next = DONE;
                else begin
                    div_start  = 1'b1;
                    state_next = DIV;
                end
            end
            DIV:   if (div_done) state_next = CHECK;
            DONE:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            w0     <= '0;
            w1     <= '0;
            iter   <= '0;
            accept <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (in_valid) begin
                    w0     <= p0;
                    w1     <= p1;
                    iter   <= '0;
                    accept <= 1'b0;
                end
                CHECK: accept <= ((c0 | c1) == 4'b0000);
                DIV: if (div_done) begin
                    if (sel0) w0 <= new_pt;
                    else      w1 <= new_pt;
                    iter <= iter + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (state == IDLE) && !rst;
    assign out_valid  = (state == DONE);
    assign out_accept = accept;
    assign q0         = w0;
    assign q1         = w1;

endmodule

// File: tb/tb_line_clipper.sv
// Directed, table-driven bench for line_clipper with hand-computed clip results.
module tb_line_clipper;
    import defines_package::*;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   in_valid = 1'b0;
    logic   in_ready;
    Point2D p0 = '0;
    Point2D p1 = '0;
    logic   out_valid;
    logic   out_ready = 1'b1;
    logic   out_accept;
    Point2D q0, q1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic signed [15:0] p0x, p0y, p1x, p1y;
        logic               acc;
        logic signed [15:0] q0x, q0y, q1x, q1y;
        int                 lat;
    } vec_t;

    vec_t vecs[8];

    line_clipper dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .p0         (p0),
        .p1         (p1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_accept (out_accept),
        .q0         (q0),
        .q1         (q1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one segment with the given out_ready; returns at the negedge where out_valid is seen.
    task automatic send_and_wait(input vec_t v, input string tag, output int lat, output bit ok);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        p0.x = v.p0x; p0.y = v.p0y;
        p1.x = v.p1x; p1.y = v.p1y;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        ok = out_valid;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.timeout: got no out_valid expected out_valid within 400 cycles", tag);
        end
    endtask

    task automatic check_result(input vec_t v, input string tag);
        check({tag, ".accept"}, 64'(out_accept), 64'(v.acc));
        if (v.acc) begin
            check({tag, ".q0x"}, 64'(q0.x), 64'(v.q0x));
            check({tag, ".q0y"}, 64'(q0.y), 64'(v.q0y));
            check({tag, ".q1x"}, 64'(q1.x), 64'(v.q1x));
            check({tag, ".q1y"}, 64'(q1.y), 64'(v.q1y));
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        bit ok;
        out_ready = 1'b1;
        send_and_wait(v, tag, lat, ok);
        if (!ok) return;
        check({tag, ".lat"}, 64'(lat), 64'(v.lat));
        check({tag, ".in_ready_done"}, 64'(in_ready), 64'd0);
        check_result(v, tag);
        @(negedge clk);
        check({tag, ".pulse"}, 64'(out_valid), 64'd0);
        check({tag, ".ready_again"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        bit ok;
        int seen;

        //          p0x   p0y  p1x   p1y  acc  q0x  q0y  q1x  q1y  lat
        vecs[0] = '{ 16'sd10,  16'sd10,  16'sd600, 16'sd400, 1'b1, 16'sd10, 16'sd10,  16'sd600, 16'sd400, 1};
        vecs[1] = '{ 16'sd0,   16'sd0,   16'sd640, 16'sd480, 1'b1, 16'sd0,  16'sd0,   16'sd640, 16'sd480, 1};
        vecs[2] = '{-16'sd10, -16'sd5,  -16'sd100, 16'sd300, 1'b0, 16'sd0,  16'sd0,   16'sd0,   16'sd0,   1};
        vecs[3] = '{ 16'sd320, 16'sd240, 16'sd320, 16'sd600, 1'b1, 16'sd320, 16'sd240, 16'sd320, 16'sd480, 34};
        vecs[4] = '{-16'sd100, 16'sd240, 16'sd100, 16'sd240, 1'b1, 16'sd0,  16'sd240, 16'sd100, 16'sd240, 34};
        vecs[5] = '{-16'sd40,  16'sd500, 16'sd700,-16'sd20,  1'b1, 16'sd0,  16'sd472, 16'sd640, 16'sd22,  133};
        vecs[6] = '{-16'sd50,  16'sd10,  16'sd10, -16'sd50,  1'b0, 16'sd0,  16'sd0,   16'sd0,   16'sd0,   34};
        vecs[7] = '{ 16'sd700, 16'sd100,-16'sd60,  16'sd100, 1'b1, 16'sd640, 16'sd100, 16'sd0,   16'sd100, 67};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst.in_ready", 64'(in_ready), 64'd0);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.out_accept", 64'(out_accept), 64'd0);
        check("rst.q0", 64'(q0), 64'd0);
        check("rst.q1", 64'(q1), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: result must hold for 5 cycles with out_ready low.
        out_ready = 1'b0;
        send_and_wait(vecs[0], "bp", lat, ok);
        if (ok) begin
            for (int c = 0; c < 5; c++) begin
                check($sformatf("bp.valid%0d", c), 64'(out_valid), 64'd1);
                check($sformatf("bp.in_ready%0d", c), 64'(in_ready), 64'd0);
                check_result(vecs[0], $sformatf("bp.hold%0d", c));
                @(negedge clk);
            end
            out_ready = 1'b1;
            @(negedge clk);
            check("bp.release_valid", 64'(out_valid), 64'd0);
            check("bp.release_ready", 64'(in_ready), 64'd1);
        end

        // Reset mid-DIV aborts with no output.
        out_ready = 1'b1;
        check("abort.in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        p0.x = vecs[3].p0x; p0.y = vecs[3].p0y;
        p1.x = vecs[3].p1x; p1.y = vecs[3].p1y;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort.rst_valid", 64'(out_valid), 64'd0);
        check("abort.rst_ready", 64'(in_ready), 64'd0);
        check("abort.rst_q1", 64'(q1), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort.after_ready", 64'(in_ready), 64'd1);
        check("abort.after_valid", 64'(out_valid), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort.no_output", 64'(seen), 64'd0);
        run_vec(vecs[4], "recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
